// File: rtl/ps2_pkg.sv
// PS/2 keyboard front-end shared definitions.
// Scan-code prefixes and the frame receiver state encoding.
package ps2_pkg;

   localparam logic [7:0] PS2_BREAK = 8'hF0;
   localparam logic [7:0] PS2_EXT   = 8'hE0;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_DATA,
      ST_PARITY,
      ST_STOP
   } frame_state_t;

endpackage

// File: rtl/ps2_key_decoder_rx.sv
// PS/2 device-to-host frame receiver.
// Synchronises and filters the pins, then deserialises 11-bit frames.
module ps2_frame_rx
   import ps2_pkg::*;
#(
   parameter int FILTER_CYCLES  = 8,
   parameter int TIMEOUT_CYCLES = 200000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   output logic [7:0] rx_byte,
   output logic       rx_valid,
   output logic       rx_err
);

   localparam int FW = $clog2(FILTER_CYCLES + 1);
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

   logic          clk_s1, clk_s2;
   logic          dat_s1, dat_s2;
   logic [FW-1:0] flt_cnt;
   logic          clk_flt;
   logic          fall;

   frame_state_t  state, state_n;
   logic [2:0]    bit_cnt, bit_n;
   logic [7:0]    sh, sh_n;
   logic          par, par_n;
   logic [TW-1:0] tmo_cnt, tmo_n;
   logic          valid_n, err_n;

   // Two-stage synchronisers; idle bus level is high.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         clk_s1 <= 1'b1;
         clk_s2 <= 1'b1;
         dat_s1 <= 1'b1;
         dat_s2 <= 1'b1;
      end else begin
         clk_s1 <= ps2_clk;
         clk_s2 <= clk_s1;
         dat_s1 <= ps2_data;
         dat_s2 <= dat_s1;
      end
   end

   // Glitch filter: level follows only a run of equal samples.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         flt_cnt <= '0;
         clk_flt <= 1'b1;
         fall    <= 1'b0;
      end else begin
         fall <= 1'b0;
         if (clk_s2 == clk_flt) begin
            flt_cnt <= '0;
         end else if (flt_cnt == FW'(FILTER_CYCLES - 1)) begin
            flt_cnt <= '0;
            clk_flt <= clk_s2;
            fall    <= clk_flt;
         end else begin
            flt_cnt <= flt_cnt + FW'(1);
         end
      end
   end

   // Frame state register and registered strobes.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= ST_IDLE;
         bit_cnt  <= '0;
         sh       <= '0;
         par      <= 1'b0;
         tmo_cnt  <= '0;
         rx_valid <= 1'b0;
         rx_err   <= 1'b0;
      end else begin
         state    <= state_n;
         bit_cnt  <= bit_n;
         sh       <= sh_n;
         par      <= par_n;
         tmo_cnt  <= tmo_n;
         rx_valid <= valid_n;
         rx_err   <= err_n;
      end
   end

   // Next-state: bit capture on fall, abort on idle timeout.
   always_comb begin
      state_n = state;
      bit_n   = bit_cnt;
      sh_n    = sh;
      par_n   = par;
      tmo_n   = tmo_cnt;
      valid_n = 1'b0;
      err_n   = 1'b0;
      if (fall) begin
         tmo_n = '0;
         unique case (state)
            ST_IDLE: begin
               if (!dat_s2) begin
                  state_n = ST_DATA;
                  bit_n   = '0;
               end
            end
            ST_DATA: begin
               sh_n  = {dat_s2, sh[7:1]};
               bit_n = bit_cnt + 3'd1;
               if (bit_cnt == 3'd7) state_n = ST_PARITY;
            end
            ST_PARITY: begin
               par_n   = dat_s2;
               state_n = ST_STOP;
            end
            ST_STOP: begin
               state_n = ST_IDLE;
               if (dat_s2 && (^{sh, par})) valid_n = 1'b1;
               else                        err_n   = 1'b1;
            end
            default: state_n = ST_IDLE;
         endcase
      end else if (state != ST_IDLE) begin
         if (tmo_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
            state_n = ST_IDLE;
            err_n   = 1'b1;
            tmo_n   = '0;
         end else begin
            tmo_n = tmo_cnt + TW'(1);
         end
      end else begin
         tmo_n = '0;
      end
   end

   assign rx_byte = sh;

endmodule

// File: rtl/ps2_key_decoder.sv
// PS/2 Set-2 key decoder feeding the melody core.
// Tracks E0/F0 prefixes and holds the most recently pressed key.
module ps2_key_decoder
   import ps2_pkg::*;
#(
   parameter int FILTER_CYCLES  = 8,
   parameter int TIMEOUT_CYCLES = 200000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   output logic [7:0] ps2_key_code,
   output logic       ps2_key_ready,
   output logic       ps2_key_ext,
   output logic       frame_error
);

   logic [7:0] rx_byte;
   logic       rx_valid;
   logic       rx_err;
   logic       brk, ext;
   logic       is_ext, is_brk, is_make, is_rel;

   ps2_frame_rx #(
      .FILTER_CYCLES (FILTER_CYCLES),
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_rx (
      .clk     (clk),
      .rst_n   (rst_n),
      .ps2_clk (ps2_clk),
      .ps2_data(ps2_data),
      .rx_byte (rx_byte),
      .rx_valid(rx_valid),
      .rx_err  (rx_err)
   );

   assign frame_error = rx_err;

   // Mutually exclusive byte classes.
   always_comb begin
      is_ext  = (rx_byte == PS2_EXT);
      is_brk  = (rx_byte == PS2_BREAK);
      is_make = !is_ext && !is_brk && !brk;
      is_rel  = !is_ext && !is_brk && brk;
   end

   // Prefix flags and held-key registers.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         brk           <= 1'b0;
         ext           <= 1'b0;
         ps2_key_code  <= 8'h00;
         ps2_key_ready <= 1'b0;
         ps2_key_ext   <= 1'b0;
      end else if (rx_valid) begin
         unique case (1'b1)
            is_ext: ext <= 1'b1;
            is_brk: brk <= 1'b1;
            is_make: begin
               ps2_key_code  <= rx_byte;
               ps2_key_ext   <= ext;
               ps2_key_ready <= 1'b1;
               brk           <= 1'b0;
               ext           <= 1'b0;
            end
            is_rel: begin
               if (rx_byte == ps2_key_code && ext == ps2_key_ext)
                  ps2_key_ready <= 1'b0;
               brk <= 1'b0;
               ext <= 1'b0;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Bench for ps2_key_decoder: directed PS/2 frames against a
// scan-code model, with per-cycle output comparison.
module tb_ps2_key_decoder;

   localparam int FILT = 8;
   localparam int TMO  = 2000;
   localparam int HALF = 25;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       ps2_clk = 1'b1;
   logic       ps2_data = 1'b1;
   logic [7:0] ps2_key_code;
   logic       ps2_key_ready;
   logic       ps2_key_ext;
   logic       frame_error;

   int         n_cmp = 0;
   int         n_bad = 0;
   int         exp_err = 0;
   int         err_seen = 0;
   logic [7:0] exp_code = 8'h00;
   logic       exp_rdy = 1'b0;
   logic       exp_ext = 1'b0;
   logic       m_brk = 1'b0;
   logic       m_ext = 1'b0;
   logic       chk_en = 1'b0;
   logic       fe_d = 1'b0;

   always #5 clk = ~clk;

   ps2_key_decoder #(
      .FILTER_CYCLES (FILT),
      .TIMEOUT_CYCLES(TMO)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .ps2_clk      (ps2_clk),
      .ps2_data     (ps2_data),
      .ps2_key_code (ps2_key_code),
      .ps2_key_ready(ps2_key_ready),
      .ps2_key_ext  (ps2_key_ext),
      .frame_error  (frame_error)
   );

   task automatic check(input string nm, input logic [31:0] act,
                        input logic [31:0] want);
      n_cmp++;
      if (act !== want) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, want);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Keyboard behaviour as seen by the host: one decoded byte at a time.
   task automatic model_byte(input logic [7:0] b);
      if (b == 8'hE0) m_ext = 1'b1;
      else if (b == 8'hF0) m_brk = 1'b1;
      else begin
         if (!m_brk) begin
            exp_code = b;
            exp_ext  = m_ext;
            exp_rdy  = 1'b1;
         end else if (b == exp_code && m_ext == exp_ext) begin
            exp_rdy = 1'b0;
         end
         m_brk = 1'b0;
         m_ext = 1'b0;
      end
   endtask

   task automatic send_bit(input logic b, input logic glitch);
      ps2_data = b;
      if (glitch) begin
         cyc(12);
         ps2_clk = 1'b0;
         cyc(3);
         ps2_clk = 1'b1;
         cyc(HALF - 15);
      end else begin
         cyc(HALF);
      end
      ps2_clk = 1'b0;
      cyc(HALF);
      ps2_clk = 1'b1;
   endtask

   task automatic send_frame(input logic [7:0] b, input logic par,
                             input logic stp, input logic glitch);
      logic [10:0] f;
      f = {stp, par, b, 1'b0};
      for (int i = 0; i < 10; i++) send_bit(f[i], glitch);
      chk_en = 1'b0;
      send_bit(f[10], 1'b0);
      cyc(HALF);
      if (stp && (^{b, par})) model_byte(b);
      else exp_err++;
      chk_en = 1'b1;
   endtask

   task automatic send_good(input logic [7:0] b);
      send_frame(b, ~^b, 1'b1, 1'b0);
   endtask

   // Output comparison against the model whenever the bus is settled.
   always @(negedge clk) begin
      if (rst_n && chk_en) begin
         check("code", {24'h0, ps2_key_code}, {24'h0, exp_code});
         check("ready", {31'h0, ps2_key_ready}, {31'h0, exp_rdy});
         check("ext", {31'h0, ps2_key_ext}, {31'h0, exp_ext});
      end
      if (rst_n && frame_error) begin
         err_seen++;
         check("fe_width", {31'h0, fe_d}, 32'h0);
      end
      fe_d <= frame_error;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

   initial begin
      // Reset with idle bus.
      rst_n = 1'b0;
      cyc(3);
      check("rst_code", {24'h0, ps2_key_code}, 32'h00);
      check("rst_ready", {31'h0, ps2_key_ready}, 32'h0);
      check("rst_ext", {31'h0, ps2_key_ext}, 32'h0);
      check("rst_fe", {31'h0, frame_error}, 32'h0);
      rst_n = 1'b1;
      cyc(20);
      chk_en = 1'b1;

      // Reset mid-frame drops the partial bits.
      send_bit(1'b0, 1'b0);
      send_bit(1'b1, 1'b0);
      send_bit(1'b0, 1'b0);
      send_bit(1'b1, 1'b0);
      chk_en = 1'b0;
      rst_n = 1'b0;
      exp_code = 8'h00; exp_rdy = 1'b0; exp_ext = 1'b0;
      m_brk = 1'b0; m_ext = 1'b0;
      cyc(3);
      rst_n = 1'b1;
      chk_en = 1'b1;
      cyc(50);
      send_good(8'h16);
      check("lit_16_code", {24'h0, ps2_key_code}, 32'h16);
      check("lit_16_ready", {31'h0, ps2_key_ready}, 32'h1);

      // Make/break sequence.
      send_good(8'h4E);
      check("lit_4e_code", {24'h0, ps2_key_code}, 32'h4E);
      send_good(8'hF0);
      send_good(8'h16);
      check("lit_old_rel_ready", {31'h0, ps2_key_ready}, 32'h1);
      send_good(8'hF0);
      send_good(8'h4E);
      check("lit_rel_ready", {31'h0, ps2_key_ready}, 32'h0);
      check("lit_rel_code", {24'h0, ps2_key_code}, 32'h4E);

      // Parity and stop-bit errors.
      send_frame(8'h16, 1'b1, 1'b1, 1'b0);
      send_frame(8'h16, 1'b0, 1'b0, 1'b0);
      check("lit_err2", err_seen, 2);
      check("lit_err_code", {24'h0, ps2_key_code}, 32'h4E);

      // Timeout after five bits, then recovery.
      send_bit(1'b0, 1'b0);
      send_bit(1'b0, 1'b1 & 1'b0);
      send_bit(1'b1, 1'b0);
      send_bit(1'b1, 1'b0);
      send_bit(1'b0, 1'b0);
      exp_err++;
      cyc(TMO + 10);
      check("lit_err3", err_seen, 3);
      send_good(8'h1C);
      check("lit_1c_code", {24'h0, ps2_key_code}, 32'h1C);
      check("lit_1c_ready", {31'h0, ps2_key_ready}, 32'h1);

      // Extended keys.
      send_good(8'hE0);
      send_good(8'h75);
      check("lit_e75_ext", {31'h0, ps2_key_ext}, 32'h1);
      send_good(8'hF0);
      send_good(8'h75);
      check("lit_plain_rel", {31'h0, ps2_key_ready}, 32'h1);
      send_good(8'hE0);
      send_good(8'hF0);
      send_good(8'h75);
      check("lit_ext_rel", {31'h0, ps2_key_ready}, 32'h0);

      // Clock glitches inside every high phase.
      send_frame(8'h16, 1'b0, 1'b1, 1'b1);
      check("lit_glitch_code", {24'h0, ps2_key_code}, 32'h16);
      check("lit_glitch_ext", {31'h0, ps2_key_ext}, 32'h0);

      cyc(20);
      check("err_count", err_seen, exp_err);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
